// File: rtl/csr_file_pkg.sv
// Shared CSR definitions: implemented addresses, mstatus bit positions, misa default.
// Imported by csr_file and csr_counter64.
package csr_file_pkg;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MISA      = 12'h301,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MTVAL     = 12'h343,
        CSR_MIP       = 12'h344,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_CYCLE     = 12'hC00,
        CSR_INSTRET   = 12'hC02,
        CSR_CYCLEH    = 12'hC80,
        CSR_INSTRETH  = 12'hC82,
        CSR_MVENDORID = 12'hF11,
        CSR_MARCHID   = 12'hF12,
        CSR_MIMPID    = 12'hF13,
        CSR_MHARTID   = 12'hF14
    } csr_addr_e;

    localparam int          MSTATUS_MIE_BIT  = 3;
    localparam int          MSTATUS_MPIE_BIT = 7;
    localparam logic [31:0] MISA_DEFAULT     = 32'h4000_0100;

    // Word-aligns an address by clearing its two low bits.
    function automatic logic [31:0] align4(input logic [31:0] v);
        return v & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with increment enable and per-half overwrite.
// A write to either half takes precedence over the increment in that cycle.
module csr_counter64
    import csr_file_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wd,
    output logic [63:0] count
);

    logic [63:0] count_r;

    // Counter state: reset, half overwrite, or increment with carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 64'd0;
        end else if (we_lo || we_hi) begin
            count_r <= {(we_hi ? wd : count_r[63:32]), (we_lo ? wd : count_r[31:0])};
        end else if (inc) begin
            count_r <= count_r + 64'd1;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file for the single-cycle RV32I core: combinational read,
// edge-committed writes, trap/mret state update and the cycle/instret counters.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] HART_ID  = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL = MISA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic        csr_we,
    input  logic [31:0] csr_wd,
    output logic [31:0] csr_rd,
    output logic        csr_illegal,
    input  logic        instr_retire,
    input  logic        trap_en,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mie_global
);

    logic        mie_bit_r;
    logic        mpie_bit_r;
    logic [31:0] mie_r;
    logic [31:0] mtvec_r;
    logic [31:0] mscratch_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;
    logic [31:0] mtval_r;

    logic [63:0] mcycle_s;
    logic [63:0] minstret_s;
    logic [31:0] mstatus_s;
    logic [31:0] rdata_s;
    logic        implemented_s;
    logic        read_only_s;
    logic        wr_ok_s;

    // Assemble the architectural view of mstatus from the two stored bits.
    always_comb begin
        mstatus_s                   = 32'd0;
        mstatus_s[MSTATUS_MIE_BIT]  = mie_bit_r;
        mstatus_s[MSTATUS_MPIE_BIT] = mpie_bit_r;
    end

    // Address decode: read data, implemented flag and read-only flag.
    always_comb begin
        rdata_s       = 32'd0;
        implemented_s = 1'b1;
        read_only_s   = (csr_addr[11:10] == 2'b11);
        case (csr_addr)
            CSR_MSTATUS:   rdata_s = mstatus_s;
            CSR_MIE:       rdata_s = mie_r;
            CSR_MTVEC:     rdata_s = mtvec_r;
            CSR_MSCRATCH:  rdata_s = mscratch_r;
            CSR_MEPC:      rdata_s = mepc_r;
            CSR_MCAUSE:    rdata_s = mcause_r;
            CSR_MTVAL:     rdata_s = mtval_r;
            CSR_MCYCLE:    rdata_s = mcycle_s[31:0];
            CSR_MCYCLEH:   rdata_s = mcycle_s[63:32];
            CSR_MINSTRET:  rdata_s = minstret_s[31:0];
            CSR_MINSTRETH: rdata_s = minstret_s[63:32];
            CSR_MISA: begin
                rdata_s     = MISA_VAL;
                read_only_s = 1'b1;
            end
            CSR_MIP: begin
                rdata_s     = 32'd0;
                read_only_s = 1'b1;
            end
            CSR_CYCLE:     rdata_s = mcycle_s[31:0];
            CSR_CYCLEH:    rdata_s = mcycle_s[63:32];
            CSR_INSTRET:   rdata_s = minstret_s[31:0];
            CSR_INSTRETH:  rdata_s = minstret_s[63:32];
            CSR_MVENDORID: rdata_s = 32'd0;
            CSR_MARCHID:   rdata_s = 32'd0;
            CSR_MIMPID:    rdata_s = 32'd0;
            CSR_MHARTID:   rdata_s = HART_ID;
            default: begin
                rdata_s       = 32'd0;
                implemented_s = 1'b0;
            end
        endcase
    end

    assign wr_ok_s     = csr_we && implemented_s && !read_only_s;
    assign csr_rd      = rdata_s;
    assign csr_illegal = !implemented_s || (csr_we && read_only_s);

    // Register updates; trap and mret own mstatus/mepc/mcause/mtval in their cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_bit_r  <= 1'b0;
            mpie_bit_r <= 1'b0;
            mie_r      <= 32'd0;
            mtvec_r    <= 32'd0;
            mscratch_r <= 32'd0;
            mepc_r     <= 32'd0;
            mcause_r   <= 32'd0;
            mtval_r    <= 32'd0;
        end else begin
            if (trap_en) begin
                mepc_r     <= align4(trap_pc);
                mcause_r   <= trap_cause;
                mtval_r    <= trap_val;
                mpie_bit_r <= mie_bit_r;
                mie_bit_r  <= 1'b0;
            end else if (mret) begin
                mie_bit_r  <= mpie_bit_r;
                mpie_bit_r <= 1'b1;
            end else if (wr_ok_s) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie_bit_r  <= csr_wd[MSTATUS_MIE_BIT];
                        mpie_bit_r <= csr_wd[MSTATUS_MPIE_BIT];
                    end
                    CSR_MEPC:   mepc_r   <= align4(csr_wd);
                    CSR_MCAUSE: mcause_r <= csr_wd;
                    CSR_MTVAL:  mtval_r  <= csr_wd;
                    default: ;
                endcase
            end
            if (wr_ok_s) begin
                case (csr_addr)
                    CSR_MIE:      mie_r      <= csr_wd;
                    CSR_MTVEC:    mtvec_r    <= align4(csr_wd);
                    CSR_MSCRATCH: mscratch_r <= csr_wd;
                    default: ;
                endcase
            end
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .we_lo (wr_ok_s && (csr_addr == CSR_MCYCLE)),
        .we_hi (wr_ok_s && (csr_addr == CSR_MCYCLEH)),
        .wd    (csr_wd),
        .count (mcycle_s)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instr_retire),
        .we_lo (wr_ok_s && (csr_addr == CSR_MINSTRET)),
        .we_hi (wr_ok_s && (csr_addr == CSR_MINSTRETH)),
        .wd    (csr_wd),
        .count (minstret_s)
    );

    assign mtvec_out  = mtvec_r;
    assign mepc_out   = mepc_r;
    assign mie_global = mie_bit_r;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: directed sequences plus random traffic, checked
// against a behavioural model of the CSR rules kept in this file.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wd;
    logic [31:0] csr_rd;
    logic        csr_illegal;
    logic        instr_retire;
    logic        trap_en;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_global;

    always #5 clk = ~clk;

    csr_file dut (
        .clk          (clk),
        .rst          (rst),
        .csr_addr     (csr_addr),
        .csr_we       (csr_we),
        .csr_wd       (csr_wd),
        .csr_rd       (csr_rd),
        .csr_illegal  (csr_illegal),
        .instr_retire (instr_retire),
        .trap_en      (trap_en),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_val     (trap_val),
        .mret         (mret),
        .mtvec_out    (mtvec_out),
        .mepc_out     (mepc_out),
        .mie_global   (mie_global)
    );

    typedef struct {
        logic [31:0] rd;
        logic        ill;
        logic [31:0] tvec;
        logic [31:0] epc;
        logic        mieg;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   chk      = 1'b0;

    // Reference state, kept as whole architectural values.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;

    function automatic bit is_rw(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82};
    endfunction

    function automatic bit is_ro(input logic [11:0] a);
        return a inside {12'h301, 12'h344, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
                         12'hF11, 12'hF12, 12'hF13, 12'hF14};
    endfunction

    function automatic logic [31:0] ref_val(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update();
        logic [63:0] nc;
        logic [63:0] ni;
        bit          lw;
        if (rst) begin
            m_mstatus = 32'd0; m_mie = 32'd0; m_mtvec = 32'd0; m_mscratch = 32'd0;
            m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0;
            m_cycle = 64'd0; m_instret = 64'd0;
        end else begin
            lw = csr_we && is_rw(csr_addr);
            nc = m_cycle + 64'd1;
            ni = m_instret + (instr_retire ? 64'd1 : 64'd0);
            if (lw && csr_addr == 12'hB00) nc = {m_cycle[63:32], csr_wd};
            if (lw && csr_addr == 12'hB80) nc = {csr_wd, m_cycle[31:0]};
            if (lw && csr_addr == 12'hB02) ni = {m_instret[63:32], csr_wd};
            if (lw && csr_addr == 12'hB82) ni = {csr_wd, m_instret[31:0]};
            if (trap_en) begin
                m_mepc    = trap_pc & ~32'd3;
                m_mcause  = trap_cause;
                m_mtval   = trap_val;
                m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            end else if (mret) begin
                m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            end else if (lw) begin
                if (csr_addr == 12'h300) m_mstatus = csr_wd & 32'h88;
                if (csr_addr == 12'h341) m_mepc = csr_wd & ~32'd3;
                if (csr_addr == 12'h342) m_mcause = csr_wd;
                if (csr_addr == 12'h343) m_mtval = csr_wd;
            end
            if (lw && csr_addr == 12'h304) m_mie = csr_wd;
            if (lw && csr_addr == 12'h305) m_mtvec = csr_wd & ~32'd3;
            if (lw && csr_addr == 12'h340) m_mscratch = csr_wd;
            m_cycle   = nc;
            m_instret = ni;
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; csr_addr = 12'h000; csr_we = 1'b0; csr_wd = 32'd0;
        instr_retire = 1'b0; trap_en = 1'b0; trap_cause = 32'd0; trap_pc = 32'd0;
        trap_val = 32'd0; mret = 1'b0;
    endtask

    // One cycle: push what the current inputs must produce, clock, advance model.
    task automatic tick();
        exp_t e;
        if (chk) begin
            e.rd   = ref_val(csr_addr);
            e.ill  = !(is_rw(csr_addr) || is_ro(csr_addr)) ||
                     (csr_we && (csr_addr[11:10] == 2'b11 || is_ro(csr_addr)));
            e.tvec = m_mtvec;
            e.epc  = m_mepc;
            e.mieg = m_mstatus[3];
            q.push_back(e);
        end
        @(posedge clk);
        model_update();
        #1;
        idle_inputs();
    endtask

    task automatic rd(input logic [11:0] a);
        csr_addr = a;
        tick();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr = a; csr_we = 1'b1; csr_wd = d;
        tick();
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compare the DUT outputs against the queued expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("csr_rd", csr_rd, e.rd);
            cmp("csr_illegal", {31'd0, csr_illegal}, {31'd0, e.ill});
            cmp("mtvec_out", mtvec_out, e.tvec);
            cmp("mepc_out", mepc_out, e.epc);
            cmp("mie_global", {31'd0, mie_global}, {31'd0, e.mieg});
        end
    end

    logic [11:0] addr_pool [0:23] = '{
        12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
        12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
        12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'hC05, 12'h000
    };

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        tick();
        chk = 1'b1;
        rst = 1'b1;
        tick();
        // Counter after reset, then reset-state outputs.
        repeat (5) rd(12'hB00);
        rd(12'hB00);
        rd(12'hB80);
        // mtvec alignment.
        wr(12'h305, 32'h8000_0103);
        rd(12'h305);
        // Carry across counter halves.
        wr(12'hB00, 32'hFFFF_FFFE);
        wr(12'hB80, 32'h0);
        repeat (3) rd(12'hB00);
        rd(12'hB80);
        rd(12'hB00);
        // Trap then mret.
        wr(12'h300, 32'h8);
        csr_addr = 12'h300; trap_en = 1'b1; trap_cause = 32'hB; trap_pc = 32'h104; trap_val = 32'h7;
        tick();
        rd(12'h341); rd(12'h342); rd(12'h343); rd(12'h300);
        csr_addr = 12'h300; mret = 1'b1;
        tick();
        rd(12'h300);
        // Read-only and unimplemented accesses.
        wr(12'hF14, 32'h55);
        rd(12'hF14);
        rd(12'h7C0);
        wr(12'hC00, 32'h1234);
        // Counter write beats retire; trap beats mepc write.
        csr_addr = 12'hB02; csr_we = 1'b1; csr_wd = 32'h10; instr_retire = 1'b1;
        tick();
        rd(12'hB02);
        csr_addr = 12'h341; csr_we = 1'b1; csr_wd = 32'h200; trap_en = 1'b1;
        trap_pc = 32'h0000_0ABE; trap_cause = 32'h2; trap_val = 32'h0;
        tick();
        rd(12'h341);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            csr_addr     = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(0, 4095))
                                                       : addr_pool[$urandom_range(0, 23)];
            csr_we       = ($urandom_range(0, 2) == 0);
            csr_wd       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            instr_retire = $urandom_range(0, 1) == 1;
            trap_en      = ($urandom_range(0, 19) == 0);
            mret         = ($urandom_range(0, 14) == 0);
            trap_cause   = $urandom;
            trap_pc      = $urandom;
            trap_val     = $urandom;
            rst          = ($urandom_range(0, 149) == 0);
            tick();
        end
        repeat (2) @(posedge clk);
        #6;
        n_assert++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
